// File: rtl/mini_src_pkg.sv
// Shared Mini-SRC definitions: datapath width, ALU opcodes and the
// multiply/divide sequencer state type.
package mini_src_pkg;

    localparam int WIDTH = 32;

    // ALU opcodes. Mul and Div are handled by muldiv_seq; the rest by alu_32.
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } muldiv_state_t;

    // True for the two opcodes the multiply/divide unit accepts.
    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
interface muldiv_seq_if #(
    parameter int WIDTH = mini_src_pkg::WIDTH
);
    logic             start;
    logic [4:0]       opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, opcode, A, B,
        input  busy, done, div_by_zero, HI, LO
    );

    modport slave (
        input  start, opcode, A, B,
        output busy, done, div_by_zero, HI, LO
    );
endinterface

// File: rtl/muldiv_seq_neg_cond.sv
// Conditional two's-complement negation, used both to take operand
// magnitudes and to re-apply the result sign.
module neg_cond #(
    parameter int N = 32
) (
    input  logic [N-1:0] value,
    input  logic         neg,
    output logic [N-1:0] result
);

    assign result = neg ? (~value + {{(N-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide unit producing the HI/LO pair for the
// Mini-SRC mul and div instructions. Works on magnitudes for 32 cycles and
// fixes the sign at the end.
module muldiv_seq
    import mini_src_pkg::*;
#(
    parameter int WIDTH = mini_src_pkg::WIDTH
) (
    input  logic         clock,
    input  logic         clear,
    muldiv_seq_if.slave  bus
);

    muldiv_state_t      state;
    logic               is_div;
    logic               sign_q;
    logic               sign_r;
    logic [WIDTH-1:0]   a_lat;
    logic [WIDTH-1:0]   b_lat;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [5:0]         count;

    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    neg_cond #(.N(WIDTH)) u_abs_a (
        .value  (a_lat),
        .neg    (a_lat[WIDTH-1]),
        .result (a_abs)
    );

    neg_cond #(.N(WIDTH)) u_abs_b (
        .value  (b_lat),
        .neg    (b_lat[WIDTH-1]),
        .result (b_abs)
    );

    // Sign fix of the full product and of quotient/remainder independently.
    neg_cond #(.N(2*WIDTH)) u_fix_prod (
        .value  (acc),
        .neg    (sign_q),
        .result (prod_fix)
    );

    neg_cond #(.N(WIDTH)) u_fix_quo (
        .value  (quo),
        .neg    (sign_q),
        .result (quo_fix)
    );

    neg_cond #(.N(WIDTH)) u_fix_rem (
        .value  (rem),
        .neg    (sign_r),
        .result (rem_fix)
    );

    // Shift-add partial sum keeps its carry so it can land in bit 63 after the shift.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};

    // Restoring-division trial step; the top bit of the difference is the borrow.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, operand};

    // Sequencer, iteration datapath and registered outputs.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            is_div  <= 1'b0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            a_lat   <= '0;
            b_lat   <= '0;
            operand <= '0;
            acc     <= '0;
            rem     <= '0;
            quo     <= '0;
            count   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start && is_muldiv_op(bus.opcode)) begin
                        state  <= PREP;
                        busy_q <= 1'b1;
                        dbz_q  <= 1'b0;
                        is_div <= (bus.opcode == OP_DIV);
                        a_lat  <= bus.A;
                        b_lat  <= bus.B;
                        sign_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        sign_r <= bus.A[WIDTH-1];
                    end else begin
                        state <= IDLE;
                    end
                end

                PREP: begin
                    if (is_div && (b_lat == '0)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        dbz_q  <= 1'b1;
                        hi_q   <= a_lat;
                        lo_q   <= '1;
                    end else begin
                        state <= CALC;
                        count <= '0;
                        if (is_div) begin
                            operand <= b_abs;
                            rem     <= '0;
                            quo     <= a_abs;
                        end else begin
                            operand <= a_abs;
                            acc     <= {{WIDTH{1'b0}}, b_abs};
                        end
                    end
                end

                CALC: begin
                    if (is_div) begin
                        if (div_diff[WIDTH]) begin
                            rem <= div_shift[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end else begin
                            rem <= div_diff[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end
                    end else if (acc[0]) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else begin
                        acc <= {1'b0, acc[2*WIDTH-1:1]};
                    end

                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end else begin
                        count <= count + 6'd1;
                    end
                end

                FIX: begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.HI          = hi_q;
    assign bus.LO          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a transaction-level model of results
// and cycle timing, checked every cycle, plus directed literal checks.
module tb_muldiv_seq;

    localparam logic [4:0] ADD_OP = 5'b00011;
    localparam logic [4:0] MUL_OP = 5'b01110;
    localparam logic [4:0] DIV_OP = 5'b01111;

    logic clock;
    logic clear;

    int tests_run    = 0;
    int tests_failed = 0;
    logic cmp_en = 1'b0;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model state: age counts edges since the accepted start, lat is the DONE edge.
    int          age;
    int          lat;
    logic [31:0] p_hi, p_lo, m_hi, m_lo;
    logic        p_dbz, m_dbz, m_busy, m_done;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, wanted %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Signed reference result computed with 64-bit arithmetic.
    function automatic void modelResult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint sa, sb, p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        dbz = 1'b0;
        if (op == MUL_OP) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            dbz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // Transaction/timing model: start accepted when idle or done, result after lat edges.
    always @(posedge clock or negedge clear) begin : model
        int          na, nlat;
        logic [31:0] nh, nl;
        logic        nd;
        if (!clear) begin
            age    <= -1;
            lat    <= 34;
            p_hi   <= '0;
            p_lo   <= '0;
            p_dbz  <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_dbz  <= 1'b0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else begin
            na   = age;
            nlat = lat;
            if ((age < 0 || age == lat) && bus.start && (bus.opcode == MUL_OP || bus.opcode == DIV_OP)) begin
                modelResult(bus.opcode, bus.A, bus.B, nh, nl, nd);
                p_hi  <= nh;
                p_lo  <= nl;
                p_dbz <= nd;
                m_dbz <= 1'b0;
                nlat  = (bus.opcode == DIV_OP && bus.B == 32'd0) ? 1 : 34;
                na    = 0;
            end else if (age >= 0 && age < lat) begin
                na = age + 1;
                if (na == lat) begin
                    m_hi  <= p_hi;
                    m_lo  <= p_lo;
                    m_dbz <= p_dbz;
                end
            end else begin
                na = -1;
            end
            age    <= na;
            lat    <= nlat;
            m_busy <= (na >= 0) && (na < nlat);
            m_done <= (na >= 0) && (na == nlat);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            checkOutput("busy", 32'(bus.busy), 32'(m_busy));
            checkOutput("done", 32'(bus.done), 32'(m_done));
            checkOutput("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
            checkOutput("HI", bus.HI, m_hi);
            checkOutput("LO", bus.LO, m_lo);
        end
    end

    // Called on a falling edge; holds start for one cycle, then scrambles operands.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.A      = a;
        bus.B      = b;
        @(negedge clock);
        bus.start  = 1'b0;
        bus.A      = $urandom;
        bus.B      = $urandom;
    endtask

    // Waits (bounded) for done; k0 is the falling-edge index at entry (1 = just after edge 0).
    task automatic waitDone(input string name, input int k0, input int exp_k, input int exp_busy);
        int k;
        int bcount;
        k = k0;
        bcount = 0;
        while (!bus.done && k < 100) begin
            if (bus.busy) bcount++;
            @(negedge clock);
            k++;
        end
        if (!bus.done) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s timeout: done not seen within %0d cycles", name, k);
        end
        checkOutput({name, " latency"}, 32'(k), 32'(exp_k));
        checkOutput({name, " busy cycles"}, 32'(bcount), 32'(exp_busy));
    endtask

    // Global watchdog.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        bus.start  = 1'b0;
        bus.opcode = 5'd0;
        bus.A      = '0;
        bus.B      = '0;
        clear      = 1'b1;
        #2 clear   = 1'b0;
        repeat (2) @(negedge clock);
        cmp_en = 1'b1;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset dbz", 32'(bus.div_by_zero), 32'd0);
        checkOutput("reset HI", bus.HI, 32'd0);
        checkOutput("reset LO", bus.LO, 32'd0);
        clear = 1'b1;
        @(negedge clock);

        // 7 * -3 = -21
        applyStimulus(MUL_OP, 32'h0000_0007, 32'hFFFF_FFFD);
        waitDone("mul 7*-3", 1, 35, 34);
        checkOutput("mul 7*-3 HI", bus.HI, 32'hFFFF_FFFF);
        checkOutput("mul 7*-3 LO", bus.LO, 32'hFFFF_FFEB);
        @(negedge clock);

        // (-2^31)^2 = 2^62
        applyStimulus(MUL_OP, 32'h8000_0000, 32'h8000_0000);
        waitDone("mul min*min", 1, 35, 34);
        checkOutput("mul min*min HI", bus.HI, 32'h4000_0000);
        checkOutput("mul min*min LO", bus.LO, 32'h0000_0000);
        @(negedge clock);

        // -7 / 2 = -3 rem -1
        applyStimulus(DIV_OP, 32'hFFFF_FFF9, 32'h0000_0002);
        waitDone("div -7/2", 1, 35, 34);
        checkOutput("div -7/2 HI", bus.HI, 32'hFFFF_FFFF);
        checkOutput("div -7/2 LO", bus.LO, 32'hFFFF_FFFD);
        @(negedge clock);

        // Overflow wraps
        applyStimulus(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("div min/-1", 1, 35, 34);
        checkOutput("div min/-1 HI", bus.HI, 32'h0000_0000);
        checkOutput("div min/-1 LO", bus.LO, 32'h8000_0000);
        @(negedge clock);

        // Divide by zero
        applyStimulus(DIV_OP, 32'h0000_0005, 32'h0000_0000);
        waitDone("div 5/0", 1, 2, 1);
        checkOutput("div 5/0 dbz", 32'(bus.div_by_zero), 32'd1);
        checkOutput("div 5/0 HI", bus.HI, 32'h0000_0005);
        checkOutput("div 5/0 LO", bus.LO, 32'hFFFF_FFFF);
        @(negedge clock);

        // Invalid opcode is ignored
        applyStimulus(ADD_OP, 32'h0000_0001, 32'h0000_0002);
        checkOutput("invalid op busy", 32'(bus.busy), 32'd0);
        checkOutput("invalid op keeps dbz", 32'(bus.div_by_zero), 32'd1);

        // Next valid start clears div_by_zero
        applyStimulus(MUL_OP, 32'h0000_0003, 32'h0000_0004);
        checkOutput("dbz cleared", 32'(bus.div_by_zero), 32'd0);
        waitDone("mul 3*4", 1, 35, 34);
        checkOutput("mul 3*4 LO", bus.LO, 32'd12);
        @(negedge clock);

        // Start during CALC is ignored
        applyStimulus(MUL_OP, 32'd100, 32'd200);
        repeat (9) @(negedge clock);
        applyStimulus(DIV_OP, 32'd9, 32'd3);
        waitDone("mul 100*200", 11, 35, 24);
        checkOutput("mul 100*200 HI", bus.HI, 32'd0);
        checkOutput("mul 100*200 LO", bus.LO, 32'd20000);

        // Back-to-back start in the DONE cycle
        applyStimulus(MUL_OP, 32'hFFFF_FFFE, 32'd5);
        waitDone("mul -2*5 b2b", 1, 35, 34);
        checkOutput("mul -2*5 HI", bus.HI, 32'hFFFF_FFFF);
        checkOutput("mul -2*5 LO", bus.LO, 32'hFFFF_FFF6);
        @(negedge clock);

        // Clear in the middle of CALC (iteration 10)
        applyStimulus(MUL_OP, 32'd12345, 32'd678);
        repeat (10) @(negedge clock);
        #2 clear = 1'b0;
        #1;
        checkOutput("clear busy", 32'(bus.busy), 32'd0);
        checkOutput("clear done", 32'(bus.done), 32'd0);
        checkOutput("clear HI", bus.HI, 32'd0);
        checkOutput("clear LO", bus.LO, 32'd0);
        @(negedge clock);
        clear = 1'b1;
        applyStimulus(MUL_OP, 32'd3, 32'd4);
        waitDone("mul 3*4 after clear", 1, 35, 34);
        checkOutput("after clear HI", bus.HI, 32'd0);
        checkOutput("after clear LO", bus.LO, 32'd12);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative signed 32×32 multiply/divide unit that sits beside `alu_32` in the Mini-SRC datapath and produces the 64-bit HI/LO result pair for the `mul` and `div` instructions. The single-cycle ALU cannot produce these results. The control unit pulses `start` with the operands and opcode already on the bus. The unit then runs a multi-cycle shift-add or shift-subtract sequence and presents HI/LO to the HI and LO registers with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clock`, input, 1: rising-edge clock.
- `clear`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request; sampled only in IDLE or DONE.
- `opcode`, input, 5: Mul = 5'b01110, Div = 5'b01111; any other value with `start` is ignored.
- `A`, input, 32: multiplicand or dividend, signed two's complement.
- `B`, input, 32: multiplier or divisor, signed two's complement.
- `busy`, output, 1: high in PREP, CALC and FIX.
- `done`, output, 1: one-cycle pulse in DONE; HI/LO are valid from this cycle on.
- `div_by_zero`, output, 1: set in DONE for a Div with B = 0; cleared at the next accepted start.
- `HI`, output, 32: Mul gives product[63:32]; Div gives the remainder.
- `LO`, output, 32: Mul gives product[31:0]; Div gives the quotient.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE or DONE, on `start` with a valid opcode, goes to PREP. The unit latches the opcode and the operands, and records the result sign:
  - Mul: A[31]^B[31].
  - Div: quotient sign A[31]^B[31]; remainder sign A[31].
- PREP converts both operands to unsigned magnitudes. 0x80000000 becomes the magnitude 2^31, which is representable as unsigned.
  - For a Div with B = 0, go to DONE.
  - Otherwise clear the iteration counter and go to CALC.
- CALC runs 32 iterations, one per cycle, using a 6-bit counter from 0 to 31. It goes to FIX after iteration 31.
  - Mul: unsigned shift-add with a 64-bit accumulator. If the current multiplier bit is set, add the multiplicand into the upper half, then shift right by 1. The carry goes into bit 63.
  - Div: restoring division with a 33-bit partial remainder. Shift left, bringing in the next dividend bit, and trial-subtract the divisor. On a non-negative result, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
- FIX applies the sign correction and loads the HI/LO output registers, then goes to DONE.
  - Mul: negate the full 64-bit product if the result sign is set.
  - Div: negate the quotient and the remainder independently by their recorded signs. Division truncates toward zero.
- DONE asserts `done` for one cycle. With no new start it returns to IDLE.
- Div by zero gives HI = A as latched, LO = 32'hFFFFFFFF, and `div_by_zero` = 1.
- Overflow case: Div 0x80000000 / −1 gives LO = 0x80000000, HI = 0. This is wrap, not an error.
- HI and LO hold the last result until the next FIX or div-by-zero DONE.
- `start` during PREP, CALC or FIX is ignored. A request with an invalid opcode leaves the state unchanged.
- `clear` low, at any time including mid-CALC, forces IDLE immediately and zeroes HI, LO, `busy`, `done`, `div_by_zero` and all internal registers.

## Timing
- Edge 0 is the edge that samples `start`. State after each edge:
  - Edge 0: PREP.
  - Edges 1–32: CALC.
  - Edge 33: FIX.
  - Edge 34: DONE.
- HI/LO are updated at edge 34.
- `done` is high for the cycle after edge 34, so latency is 35 cycles from start.
- Div by zero: PREP after edge 0, DONE after edge 1. HI/LO are written at edge 1.
- Back-to-back requests: a `start` in DONE is accepted at the same edge that leaves DONE, with no IDLE cycle between operations.
- Operands are latched at edge 0; A and B may change from the next cycle.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `mini_src_pkg`:
  - All ALU opcode constants (Add … Or, Mul, Div).
  - The `muldiv_state_t` enum.
  - The `WIDTH` constant.
- Sub-module `neg_cond` conditionally two's-complement negates a value. It is parameterized by width and instantiated for the operand magnitudes (32-bit) and for the sign fix (64-bit and 32-bit).
- The FSM, counter and iteration datapath stay in `muldiv_seq`.

## Test plan
- Mul 7 × −3 (0x00000007, 0xFFFFFFFD): expect HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; `done` after edge 34; `busy` high for exactly 34 cycles.
- Mul 0x80000000 × 0x80000000: expect HI = 0x40000000, LO = 0x00000000.
- Div −7 / 2: expect LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). Div 0x80000000 / 0xFFFFFFFF: expect LO = 0x80000000, HI = 0.
- Div 5 / 0: expect `done` after edge 1, `div_by_zero` = 1, HI = 5, LO = 0xFFFFFFFF. The next valid start clears `div_by_zero`.
- `start` pulsed during CALC with different operands is ignored and the first result is unchanged. A start in the DONE cycle is accepted, and its `done` arrives 35 cycles later.
- Drive `clear` low at iteration 10 of CALC: expect `busy`, `done`, HI and LO at 0 immediately, and state IDLE. A fresh Mul 3 × 4 afterwards gives LO = 12.
